// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-test session controller and its LFSR delay generator.
package reaction_pkg;

    localparam int unsigned TIME_W    = 14;
    localparam int unsigned MAX_MS    = 9999;
    localparam int unsigned LFSR_W    = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (register bits 7,5,4,3)
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RUN       = 3'd2,
        ST_SHOW_RND  = 3'd3,
        ST_SHOW_BEST = 3'd4,
        ST_SHOW_AVG  = 3'd5
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_delay_gen.sv
// 8-bit Fibonacci LFSR producing a 3-bit pseudo-random delay selector; advances only when stepped.
module lfsr_delay_gen
    import reaction_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    output logic [2:0] o_code
);

    logic [LFSR_W-1:0] r_lfsr;

    // Seed is non-zero, and the polynomial is maximal, so the register never locks up at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_code = r_lfsr[2:0];

endmodule

// File: rtl/reaction_session_ctrl.sv
// Multi-round reaction-test session scheduler: launches rounds, tracks best/average, drives display value.
// Build option: REACTION_BEST_PERSIST_EN keeps the best time across sessions until reset.
module reaction_session_ctrl #(
    parameter int unsigned ROUNDS  = 4,
    parameter int unsigned TIME_W  = reaction_pkg::TIME_W,
    parameter int unsigned MAX_MS  = reaction_pkg::MAX_MS,
    parameter int unsigned SHOW_MS = 1500
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ms_tick,
    input  logic                        start_btn,
    input  logic                        round_done,
    input  logic                        round_err,
    input  logic [TIME_W-1:0]           round_time,
    output logic                        round_start,
    output logic [2:0]                  delay_code,
    output logic [TIME_W-1:0]           disp_value,
    output logic                        disp_err,
    output logic [$clog2(ROUNDS)-1:0]   round_idx,
    output logic                        session_busy
);

    import reaction_pkg::state_t;
    import reaction_pkg::ST_IDLE;
    import reaction_pkg::ST_ARM;
    import reaction_pkg::ST_RUN;
    import reaction_pkg::ST_SHOW_RND;
    import reaction_pkg::ST_SHOW_BEST;
    import reaction_pkg::ST_SHOW_AVG;

    localparam int unsigned IDX_W = $clog2(ROUNDS);
    localparam int unsigned SUM_W = TIME_W + IDX_W;
    localparam int unsigned DW_W  = $clog2(SHOW_MS + 1);

    state_t              r_state, w_state_nxt;
    logic                r_btn_q;
    logic                w_start_rise;
    logic [SUM_W-1:0]    r_sum, w_sum_nxt;
    logic [TIME_W-1:0]   r_best, w_best_nxt;
    logic [TIME_W-1:0]   r_disp_value, w_disp_value_nxt;
    logic [TIME_W-1:0]   w_t;
    logic                r_disp_err, w_disp_err_nxt;
    logic [2:0]          r_delay_code, w_delay_code_nxt;
    logic                r_round_start, w_round_start_nxt;
    logic [IDX_W-1:0]    r_round_idx, w_round_idx_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_was_err, w_was_err_nxt;
    logic [DW_W-1:0]     r_dwell, w_dwell_nxt;
    logic                r_entry, w_entry_nxt;
    logic                w_dwell_done;
    logic                w_lfsr_step;
    logic [2:0]          w_lfsr_code;

    lfsr_delay_gen u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_lfsr_step),
        .o_code (w_lfsr_code)
    );

    assign w_start_rise = start_btn & ~r_btn_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            // Held high in reset so a button already down at release is not taken as a new press
            r_btn_q       <= 1'b1;
            r_sum         <= '0;
            r_best        <= TIME_W'(MAX_MS);
            r_disp_value  <= '0;
            r_disp_err    <= 1'b0;
            r_delay_code  <= '0;
            r_round_start <= 1'b0;
            r_round_idx   <= '0;
            r_busy        <= 1'b0;
            r_was_err     <= 1'b0;
            r_dwell       <= '0;
            r_entry       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_btn_q       <= start_btn;
            r_sum         <= w_sum_nxt;
            r_best        <= w_best_nxt;
            r_disp_value  <= w_disp_value_nxt;
            r_disp_err    <= w_disp_err_nxt;
            r_delay_code  <= w_delay_code_nxt;
            r_round_start <= w_round_start_nxt;
            r_round_idx   <= w_round_idx_nxt;
            r_busy        <= w_busy_nxt;
            r_was_err     <= w_was_err_nxt;
            r_dwell       <= w_dwell_nxt;
            r_entry       <= w_entry_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_sum_nxt         = r_sum;
        w_best_nxt        = r_best;
        w_disp_value_nxt  = r_disp_value;
        w_disp_err_nxt    = r_disp_err;
        w_delay_code_nxt  = r_delay_code;
        w_round_start_nxt = 1'b0;
        w_round_idx_nxt   = r_round_idx;
        w_was_err_nxt     = r_was_err;
        w_lfsr_step       = 1'b0;
        w_t               = (round_time > TIME_W'(MAX_MS)) ? TIME_W'(MAX_MS) : round_time;
        // The tick landing in a state's first cycle is deliberately not counted
        w_dwell_done      = ms_tick && !r_entry && (r_dwell == DW_W'(SHOW_MS - 1));

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt     = ST_ARM;
                    w_sum_nxt       = '0;
                    w_round_idx_nxt = '0;
`ifdef REACTION_BEST_PERSIST_EN
                    w_best_nxt      = r_best;
`else
                    w_best_nxt      = TIME_W'(MAX_MS);
`endif
                end
            end
            ST_ARM: begin
                w_round_start_nxt = 1'b1;
                w_delay_code_nxt  = w_lfsr_code;
                w_lfsr_step       = 1'b1;
                w_state_nxt       = ST_RUN;
            end
            ST_RUN: begin
                if (round_err) begin
                    w_disp_err_nxt = 1'b1;
                    w_was_err_nxt  = 1'b1;
                    w_state_nxt    = ST_SHOW_RND;
                end else if (round_done) begin
                    w_disp_value_nxt = w_t;
                    w_sum_nxt        = r_sum + SUM_W'(w_t);
                    w_best_nxt       = (w_t < r_best) ? w_t : r_best;
                    w_was_err_nxt    = 1'b0;
                    w_state_nxt      = ST_SHOW_RND;
                end
            end
            ST_SHOW_RND: begin
                if (w_dwell_done) begin
                    w_disp_err_nxt = 1'b0;
                    if (r_was_err) begin
                        w_state_nxt = ST_ARM;
                    end else if (r_round_idx < IDX_W'(ROUNDS - 1)) begin
                        w_round_idx_nxt = r_round_idx + IDX_W'(1);
                        w_state_nxt     = ST_ARM;
                    end else begin
                        w_disp_value_nxt = r_best;
                        w_state_nxt      = ST_SHOW_BEST;
                    end
                end
            end
            ST_SHOW_BEST: begin
                if (w_dwell_done) begin
                    w_disp_value_nxt = TIME_W'(r_sum >> IDX_W);
                    w_state_nxt      = ST_SHOW_AVG;
                end
            end
            ST_SHOW_AVG: begin
                if (w_dwell_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_entry_nxt = (w_state_nxt != r_state);
        if (w_entry_nxt) begin
            w_dwell_nxt = '0;
        end else if (ms_tick && !r_entry) begin
            w_dwell_nxt = r_dwell + DW_W'(1);
        end else begin
            w_dwell_nxt = r_dwell;
        end
    end

    assign round_start  = r_round_start;
    assign delay_code   = r_delay_code;
    assign disp_value   = r_disp_value;
    assign disp_err     = r_disp_err;
    assign round_idx    = r_round_idx;
    assign session_busy = r_busy;

endmodule

// File: doc/reaction_session_ctrl.md
Name: reaction_session_ctrl

Overview:
- Session scheduler that sits above the reaction-round FSM/timer pair and sequences a multi-round reaction test.
- Launches ROUNDS rounds, each with a pseudo-random pre-stimulus delay code.
- Captures each valid reaction time and tracks session best and average.
- Owns the value/error selection feeding the 7-segment driver: per-round result, then best, then average.

Parameters:
- ROUNDS, 4, rounds per session; power of 2, 2..16.
- TIME_W, 14, width of all millisecond values.
- MAX_MS, 9999, saturation ceiling for captured times (4-digit display limit).
- SHOW_MS, 1500, dwell of each result screen, counted in ms_tick pulses.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ms_tick  in  1  one-cycle pulse every 1 ms.
- start_btn  in  1  synchronized, debounced level; controller edge-detects the rising edge.
- round_done  in  1  one-cycle pulse: round ended with a valid reaction.
- round_err  in  1  one-cycle pulse: false start.
- round_time  in  TIME_W  reaction ms; valid with round_done.
- round_start  out  1  one-cycle pulse launching a round.
- delay_code  out  3  random delay selector; stable from round_start until round end.
- disp_value  out  TIME_W  value to display driver.
- disp_err  out  1  display shows error pattern.
- round_idx  out  $clog2(ROUNDS)  current round index, 0-based.
- session_busy  out  1  high from ARM until SHOW_AVG ends.

Behaviour:
- Reset:
  - state IDLE; all outputs 0.
  - best = MAX_MS, sum = 0, round_idx = 0, LFSR = 8'hA5 (never 0).
- States: IDLE, ARM, RUN, SHOW_RND, SHOW_BEST, SHOW_AVG.
- IDLE -> ARM on rising edge of start_btn.
  - Clears sum, round_idx and best (see optional feature).
- ARM:
  - Single cycle: asserts round_start.
  - Latches delay_code = LFSR[2:0].
  - Advances the LFSR (x^8+x^6+x^5+x^4+1) once.
  - Next state RUN.
- RUN waits for round_done or round_err; the same cycle sets the transition and the registered outputs appear one cycle later.
  - round_err (wins if simultaneous with round_done): disp_err=1, round_idx unchanged (round is retried), -> SHOW_RND.
  - round_done: t = min(round_time, MAX_MS); disp_value=t; sum+=t; best=min(best,t); -> SHOW_RND.
- SHOW_RND:
  - Counts SHOW_MS ms_ticks, then clears disp_err.
  - If it was an error, or round_idx < ROUNDS-1 (incrementing round_idx on valid rounds): -> ARM.
  - Otherwise -> SHOW_BEST.
- SHOW_BEST: disp_value=best; dwell SHOW_MS ticks -> SHOW_AVG.
- SHOW_AVG:
  - disp_value = sum >> log2(ROUNDS); dwell SHOW_MS ticks -> IDLE.
  - disp_value holds its last value in IDLE.
- Sum register is TIME_W+log2(ROUNDS) bits wide and never overflows, because inputs saturate at MAX_MS.
- Dwell counter:
  - Cleared on every state entry.
  - An ms_tick in the entry cycle is not counted.
- start_btn edges are ignored in every state except IDLE.
- session_busy is high in all states except IDLE.
- Stray round_done/round_err outside RUN are ignored.
- rst_n low mid-session returns immediately to reset values; no round_start is issued until a new start edge.

Optional Feature:
- Macro: REACTION_BEST_PERSIST_EN.
- Defined: best is cleared only by rst_n, never on session start, so SHOW_BEST displays the all-time best since reset.
- Undefined: best reloads MAX_MS at each IDLE->ARM.

Decomposition:
- Shared package reaction_pkg holds:
  - state enum;
  - TIME_W;
  - MAX_MS;
  - LFSR seed/taps constants.
- One sub-module, lfsr_delay_gen (8-bit Fibonacci LFSR with step enable and 3-bit tap output), instantiated once.

Test Plan (ROUNDS=4, SHOW_MS=2, ms_tick every 10 cycles):
- Reset, start edge -> round_start pulses exactly once, 1 cycle after the ARM entry edge; delay_code = 3'b101 (seed A5); session_busy=1.
- Rounds return 200, 300, 100, 400 -> SHOW_RND shows each value; SHOW_BEST=100; SHOW_AVG=250; then IDLE, busy=0.
- Round 1 round_err, then 250 -> disp_err=1 for 2 ticks, round_idx stays 1, extra round_start issued; final avg counts only 4 valid times.
- round_time=12000 -> disp_value=9999; sum adds 9999.
- round_done and round_err in the same cycle -> treated as error, sum unchanged.
- rst_n low mid-RUN, then high -> all outputs 0, no round_start until a new start edge.
- With REACTION_BEST_PERSIST_EN: session 1 best 100, session 2 all times ≥150 -> SHOW_BEST=100 (without the macro: 150).
